reorder_buffer: RTL

In-order retirement buffer directly downstream of the commit stage. It allocates tags at issue, accepts out-of-order results from the commit stage (write, 6-bit tag, entry), and releases entries strictly in program order to the writeback/register-file stage through a valid/ready handshake. A flush empties the buffer on a branch mispredict or an exception.

---
 rtl/reorder_buffer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement buffer that sits directly after the commit stage.
// Issue allocates tags from the tail. The commit stage writes results back out
// of order by tag. Entries leave strictly in program order through a registered
// valid/ready output stage. A flush (mispredict or exception) empties the buffer.
//
// Optional feature: define ROB_CHECK_EN to add a registered illegal_write_o
// pulse. The pulse fires when a write targets a tag outside the allocated window
// [head, tail) or an entry that is already valid. Such a write is dropped.
// Without the macro, every write is accepted as-is.
//
// Parameters
//   ROB_DEPTH       number of entries, power of two in 2..64. Tags are 6 bits
//                   wide; smaller depths use the low log2(ROB_DEPTH) bits.
//
// Ports
//   clk_i           clock
//   rst_n_i         asynchronous active-low reset
//   flush_i         synchronous flush, overrides every other request
//   alloc_i         issue requests one tag
//   alloc_tag_o     tag handed to issue (current tail)
//   full_o/empty_o  occupancy flags, derived from count
//   write_i         commit stage writes a result...
//   write_tag_i     ...into this entry
//   write_entry_i   ...with this payload
//   retire_valid_o  head entry presented to writeback
//   retire_ready_i  writeback accepts the presented entry
//   retire_entry_o  presented payload
//   retire_tag_o    presented tag
//   illegal_write_o (ROB_CHECK_EN only) one-cycle pulse on a rejected write
// -----------------------------------------------------------------------------

package reorder_buffer_pkg;
  typedef struct packed {
    logic [4:0]  rd;    // destination register
    logic [31:0] data;  // result value
    logic        exc;   // result raised an exception
  } rob_entry_t;
endpackage

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       flush_i,
  input  logic       alloc_i,
  output logic [5:0] alloc_tag_o,
  output logic       full_o,
  output logic       empty_o,
  input  logic       write_i,
  input  logic [5:0] write_tag_i,
  input  rob_entry_t write_entry_i,
  output logic       retire_valid_o,
  input  logic       retire_ready_i,
  output rob_entry_t retire_entry_o,
`ifdef ROB_CHECK_EN
  output logic       illegal_write_o,
`endif
  output logic [5:0] retire_tag_o
);

  localparam int AW = $clog2(ROB_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_EMPTY, ST_PRESENT} state_t;

  rob_entry_t           mem [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] valid;
  logic [ROB_DEPTH-1:0] valid_next;
  logic [AW-1:0]        head;
  logic [AW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  state_t               state;

  logic [AW-1:0] wr_idx;
  logic          alloc_ok;
  logic          write_ok;
  logic          retire_fire;
  logic          load;

  assign wr_idx      = write_tag_i[AW-1:0];
  assign full_o      = (count == CW'(ROB_DEPTH));
  assign empty_o     = (count == '0);
  assign alloc_tag_o = 6'(tail);
  assign alloc_ok    = alloc_i && !full_o;
  assign retire_fire = retire_valid_o && retire_ready_i;

  // The head entry moves into the output register when the stage is empty, or
  // when the presented entry is being taken this cycle (back-to-back retire).
  // The check uses the registered valid bit. A write to the head tag in this
  // same cycle therefore only becomes eligible on the next cycle.
  assign load = valid[head] && ((state == ST_EMPTY) || retire_ready_i);

  // An entry leaves the count only when writeback takes it from the output
  // register, not when it is loaded into that register.
  assign count_next = count + CW'(alloc_ok) - CW'(retire_fire);

`ifdef ROB_CHECK_EN
  logic [AW-1:0] wr_off;
  logic [CW-1:0] window;
  logic          write_legal;

  // The writable window starts at head. An entry already moved into the output
  // register is no longer writable, so it is taken out of the window size.
  assign wr_off      = wr_idx - head;
  assign window      = count - CW'(state == ST_PRESENT);
  assign write_legal = ({1'b0, wr_off} < window) && !valid[wr_idx];
  assign write_ok    = write_i && write_legal;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      illegal_write_o <= 1'b0;
    end else begin
      illegal_write_o <= write_i && !write_legal && !flush_i;
    end
  end
`else
  assign write_ok = write_i;
`endif

  // Valid-bit updates are applied in order. Allocation clears the new slot. A
  // write sets its slot. A load clears the head slot last, so a stray duplicate
  // write to the head cannot make it retire twice.
  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a path
    // that skips the assignment infers a latch.
    valid_next = valid;
    if (alloc_ok) valid_next[tail]   = 1'b0;
    if (write_ok) valid_next[wr_idx] = 1'b1;
    if (load)     valid_next[head]   = 1'b0;
  end

  // NOTE: the payload RAM has no reset. Only the valid bits decide whether an
  // entry is live, so clearing storage would just cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (write_ok && !flush_i) mem[wr_idx] <= write_entry_i;
  end

  // Pointers, count, valid bits and the retire output-stage FSM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples pre-edge values, whatever order the statements appear in.
    if (!rst_n_i) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid          <= '0;
      state          <= ST_EMPTY;
      retire_valid_o <= 1'b0;
      retire_entry_o <= '0;
      retire_tag_o   <= '0;
    end else if (flush_i) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid          <= '0;
      state          <= ST_EMPTY;
      retire_valid_o <= 1'b0;
      retire_entry_o <= '0;
      retire_tag_o   <= '0;
    end else begin
      valid <= valid_next;
      count <= count_next;
      if (alloc_ok) tail <= tail + AW'(1);

      if (load) begin
        head           <= head + AW'(1);
        retire_entry_o <= mem[head];
        retire_tag_o   <= 6'(head);
        retire_valid_o <= 1'b1;
        state          <= ST_PRESENT;
      end else if ((state == ST_PRESENT) && retire_ready_i) begin
        retire_valid_o <= 1'b0;
        state          <= ST_EMPTY;
      end
    end
  end

endmodule
